// File: rtl/seven_seg_scanner_pkg.sv
// seven_seg_scanner_pkg: shared constants, FSM states, segment table and BCD helper
package seven_seg_scanner_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int BCD_W = 4;
  localparam logic [13:0] MAX_VALUE = 14'd9999;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++)
      r[BCD_W*i +: BCD_W] = b[BCD_W*i +: BCD_W] >= 4'd5 ? b[BCD_W*i +: BCD_W] + 4'd3 : b[BCD_W*i +: BCD_W];
    return r;
  endfunction
endpackage

// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if: load/value handshake and display pin bundle
interface seven_seg_scanner_if;
  logic        load;
  logic [13:0] value;
  logic [3:0]  dp_mask;
  logic        busy;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  modport master (output load, value, dp_mask, input busy, an, seg, dp);
  modport slave (input load, value, dp_mask, output busy, an, seg, dp);
endinterface

// File: rtl/seven_seg_scanner_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one bit per cycle, saturating at 9999
module bin2bcd_seq
  import seven_seg_scanner_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
);
  state_t state, state_n;
  logic [13:0] sh;
  logic [3:0]  cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE ? (start ? CONV : IDLE) :
              state == CONV ? (cnt == 4'd13 ? DONE : CONV) : IDLE;
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh  <= '0;
      bcd <= '0;
      cnt <= '0;
    end else if (state == IDLE && start) begin
      sh  <= bin > MAX_VALUE ? MAX_VALUE : bin;
      bcd <= '0;
      cnt <= '0;
    end else if (state == CONV) begin
      {bcd, sh} <= {add3(bcd), sh} << 1;
      cnt <= cnt + 4'd1;
    end
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: 4-digit multiplexed 7-segment driver with BCD conversion and blank gap
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input logic clk,
  input logic rst,
  seven_seg_scanner_if.slave bus
);
  localparam int CW = $clog2(SLOT_CYCLES);
  logic          start, done, busy, on, dp_h;
  logic [15:0]   bcd, dig;
  logic [3:0]    dp_pend, dpm, lit, show, an_h;
  logic [6:0]    seg_h;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  assign start = bus.load & ~busy;
  assign bus.busy = busy;
  bin2bcd_seq u_conv (
    .clk(clk), .rst(rst), .start(start), .bin(bus.value),
    .busy(busy), .done(done), .bcd(bcd)
  );
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lit
    assign lit[k] = |dig[BCD_W*k +: BCD_W] | dpm[k];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dp_pend <= '0;
      dpm     <= '0;
      dig     <= '0;
    end else begin
      if (start) dp_pend <= bus.dp_mask;
      if (done) begin
        dig <= bcd;
        dpm <= dp_pend;
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt == CW'(SLOT_CYCLES - 1) ? '0 : cnt + 1'b1;
      if (cnt == CW'(SLOT_CYCLES - 1)) idx <= idx + 2'd1;
    end
  always_comb begin
    show  = {lit[3], |lit[3:2], |lit[3:1], 1'b1};
    on    = cnt >= CW'(BLANK_CYCLES) && show[idx];
    an_h  = on ? 4'b0001 << idx : 4'b0000;
    seg_h = on ? SEG_TABLE[dig[{idx, 2'b00} +: 4]] : 7'h00;
    dp_h  = on & dpm[idx];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.an  <= {4{ACTIVE_LOW}};
      bus.seg <= {7{ACTIVE_LOW}};
      bus.dp  <= ACTIVE_LOW;
    end else begin
      bus.an  <= an_h ^ {4{ACTIVE_LOW}};
      bus.seg <= seg_h ^ {7{ACTIVE_LOW}};
      bus.dp  <= dp_h ^ ACTIVE_LOW;
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: randomized self-checking bench against a value-level display model
module tb_seven_seg_scanner;
  logic clk, rst;
  seven_seg_scanner_if bus();
  seven_seg_scanner #(.SLOT_CYCLES(20), .BLANK_CYCLES(4), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int total = 0, bad = 0;
  int cyc, acc_e, sw_at, old_v, new_v;
  logic [3:0] old_m, new_m;
  function automatic logic exp_busy(int k);
    return k >= acc_e && k <= acc_e + 14;
  endfunction
  function automatic logic [12:0] exp_out(int k);
    int v, p, i, d, pw;
    logic [3:0] m;
    logic on;
    v  = k >= sw_at ? new_v : old_v;
    m  = k >= sw_at ? new_m : old_m;
    p  = (k - 1) % 20;
    i  = ((k - 1) / 20) % 4;
    pw = 10 ** i;
    d  = (v / pw) % 10;
    on = k >= 1 && p >= 4 && (i == 0 || v >= pw || (m >> i) != 0);
    return {exp_busy(k), on ? ~(4'b0001 << i) : 4'hF, on ? ~pat[d] : 7'h7F, on ? ~m[i] : 1'b1};
  endfunction
  function automatic logic [12:0] obs();
    return {bus.busy, bus.an, bus.seg, bus.dp};
  endfunction
  task automatic drive(input logic ld, input int v, input logic [3:0] m);
    bus.load = ld;
    bus.value = 14'(v);
    bus.dp_mask = m;
  endtask
  task automatic step();
    @(posedge clk);
    if (bus.load && !exp_busy(cyc)) begin
      acc_e = cyc + 1;
      old_v = new_v;
      old_m = new_m;
      new_v = bus.value > 14'd9999 ? 9999 : int'(bus.value);
      new_m = bus.dp_mask;
      sw_at = acc_e + 16;
    end
    cyc++;
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if (obs() !== 13'h0FFF) begin
      bad++;
      $display("FAIL reset_assert got=%h exp=%h", obs(), 13'h0FFF);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0; acc_e = -100; sw_at = 0; old_v = 0; new_v = 0; old_m = 0; new_m = 0;
    total++;
    if (obs() !== exp_out(cyc)) begin
      bad++;
      $display("FAIL reset_release got=%h exp=%h", obs(), exp_out(cyc));
    end
  endtask
  task automatic test_idle();
    repeat (200) begin
      step();
      total++;
      if (obs() !== exp_out(cyc)) begin
        bad++;
        $display("FAIL idle cyc=%0d got=%h exp=%h", cyc, obs(), exp_out(cyc));
      end
    end
  endtask
  task automatic test_value(input int v, input logic [3:0] m);
    drive(1'b1, v, m);
    step();
    drive(1'b0, 0, 4'h0);
    repeat (110) begin
      total++;
      if (obs() !== exp_out(cyc)) begin
        bad++;
        $display("FAIL value_%0d cyc=%0d got=%h exp=%h", v, cyc, obs(), exp_out(cyc));
      end
      step();
    end
  endtask
  task automatic test_ignored_load();
    drive(1'b1, 42, 4'h0);
    step();
    drive(1'b0, 0, 4'h0);
    repeat (4) step();
    total++;
    if (obs() !== exp_out(cyc)) begin
      bad++;
      $display("FAIL busy_phase cyc=%0d got=%h exp=%h", cyc, obs(), exp_out(cyc));
    end
    drive(1'b1, 999, 4'hF);
    step();
    drive(1'b0, 0, 4'h0);
    repeat (110) begin
      total++;
      if (obs() !== exp_out(cyc)) begin
        bad++;
        $display("FAIL ignored_load cyc=%0d got=%h exp=%h", cyc, obs(), exp_out(cyc));
      end
      step();
    end
  endtask
  task automatic test_reset_mid_conv();
    drive(1'b1, 8888, 4'h3);
    step();
    drive(1'b0, 0, 4'h0);
    repeat (5) step();
    #2;
    test_reset();
    repeat (100) begin
      step();
      total++;
      if (obs() !== exp_out(cyc)) begin
        bad++;
        $display("FAIL after_abort cyc=%0d got=%h exp=%h", cyc, obs(), exp_out(cyc));
      end
    end
  endtask
  task automatic test_random();
    repeat (25) begin
      drive(1'b1, int'($urandom_range(16383)), 4'($urandom_range(15)));
      step();
      drive(1'b0, 0, 4'h0);
      repeat ($urandom_range(100)) begin
        total++;
        if (obs() !== exp_out(cyc)) begin
          bad++;
          $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs(), exp_out(cyc));
        end
        step();
      end
    end
  endtask
  initial begin
    drive(1'b0, 0, 4'h0);
    rst = 1'b1;
    #3;
    test_reset();
    test_idle();
    test_value(1234, 4'h0);
    test_value(10000, 4'h0);
    test_value(16383, 4'h0);
    test_value(7, 4'h0);
    test_value(0, 4'h0);
    test_value(5, 4'b0100);
    test_ignored_load();
    test_reset_mid_conv();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
